// File: rtl/mem_bank_arbiter_pkg.sv
// mem_arb_pkg: shared types, widths and half-word helpers for the
// mem_bank_arbiter slice (arbiter core, requester/bank interface, rr_arb2).
package mem_arb_pkg;

   localparam int HW_AW = 6;   // halfword address width
   localparam int WA_W  = 5;   // word address width
   localparam int HW_W  = 16;  // halfword width
   localparam int W_W   = 32;  // word width

   localparam logic HALF_LO = 1'b0;
   localparam logic HALF_HI = 1'b1;

   // Explicit encodings keep the state register readable on legacy probes.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      DONE = 3'd4
   } state_e;

   // Selected half of a bank word.
   function automatic logic [HW_W-1:0] pick_half(input logic [W_W-1:0] word,
                                                 input logic            half);
      return (half == HALF_HI) ? word[W_W-1:HW_W] : word[HW_W-1:0];
   endfunction

   // Replace one half of the old word, keeping the other half intact.
   function automatic logic [W_W-1:0] merge_half(input logic [W_W-1:0]  old_word,
                                                 input logic [HW_W-1:0] data,
                                                 input logic            half);
      return (half == HALF_LO) ? {old_word[W_W-1:HW_W], data}
                               : {data, old_word[HW_W-1:0]};
   endfunction

endpackage

// File: rtl/mem_bank_arbiter_if.sv
// mem_bank_arbiter_if: requester-side handshakes plus the bank port.
//   req/we/addr/wdata : requester 0/1 access request and payload
//   gnt/done/rdata    : accept pulse, completion pulse, held read data
//   busy              : arbiter is servicing an access
//   mem_addr/we/di/do : word-wide bank port
// Modports: slave = arbiter side, master = requesters plus bank.
interface mem_bank_arbiter_if;
   import mem_arb_pkg::*;

   logic            req0,  req1;
   logic            we0,   we1;
   logic [HW_AW-1:0] addr0, addr1;
   logic [HW_W-1:0]  wdata0, wdata1;
   logic            gnt0,  gnt1;
   logic            done0, done1;
   logic [HW_W-1:0]  rdata0, rdata1;
   logic            busy;
   logic [WA_W-1:0]  mem_addr;
   logic            mem_we;
   logic [W_W-1:0]   mem_di;
   logic [W_W-1:0]   mem_do;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_do,
      output gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
             mem_addr, mem_we, mem_di
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_do,
      input  gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
             mem_addr, mem_we, mem_di
   );
endinterface

// File: rtl/mem_bank_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i[1:0] : request vector
//   en_i       : arbitration window; no grant outside it
//   gnt_o[1:0] : one-hot grant, combinational
// last_q remembers the port granted most recently and only moves on a grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);

   logic last_q;  // 1 = port 1 granted last

   // NOTE: assign a default first so every path drives gnt_o and no latch is inferred.
   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
         endcase
      end
   end

   // NOTE: non-blocking assignments for flops so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       last_q <= 1'b1;
      else if (|gnt_o)  last_q <= gnt_o[1];
   end

endmodule

// File: rtl/mem_bank_arbiter.sv
// mem_bank_arbiter: two-requester arbiter/sequencer for the 32 x 32-bit bank.
// Halfword writes are read-modify-write so the other half survives.
//   clk      : system clock (bank shares it)
//   RSTN     : asynchronous active-low reset
//   bus      : mem_bank_arbiter_if.slave (requesters and bank port)
//   cnt0/1   : completed-access counters, only with MEM_ARB_STATS_EN defined
// Parameter RD_LAT (1..4): bank cycles from address valid to mem_do valid.
// Sequence: IDLE (grant) -> RD x RD_LAT -> CAP -> [WR] -> DONE -> IDLE.
module mem_bank_arbiter
   import mem_arb_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              RSTN,
   mem_bank_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [HW_W-1:0]   cnt0,
   output logic [HW_W-1:0]   cnt1
`endif
);

   localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

   state_e           state_q, state_d;
   logic             run_q;       // holds off grants until the first edge after reset
   logic [1:0]       arb_gnt;
   logic             arb_en;
   logic             sel_q;       // granted port
   logic             we_q;
   logic             half_q;
   logic [HW_W-1:0]  wdata_q;
   logic [W_W-1:0]   old_q;
   logic [HW_W-1:0]  rdata0_q, rdata1_q;
   logic [WA_W-1:0]  mem_addr_q;
   logic [2:0]       lat_q;

   // Payload of whichever port the arbiter picks this cycle.
   logic             pick_we;
   logic [HW_AW-1:0] pick_addr;
   logic [HW_W-1:0]  pick_wdata;

   assign arb_en     = (state_q == IDLE) && run_q;
   assign pick_we    = arb_gnt[1] ? bus.we1    : bus.we0;
   assign pick_addr  = arb_gnt[1] ? bus.addr1  : bus.addr0;
   assign pick_wdata = arb_gnt[1] ? bus.wdata1 : bus.wdata0;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (RSTN),
      .req_i ({bus.req1, bus.req0}),
      .en_i  (arb_en),
      .gnt_o (arb_gnt)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|arb_gnt) state_d = RD;
         RD:      if (lat_q == LAT_LAST) state_d = CAP;
         CAP:     state_d = we_q ? WR : DONE;
         WR:      state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         state_q    <= IDLE;
         run_q      <= 1'b0;
         sel_q      <= 1'b0;
         we_q       <= 1'b0;
         half_q     <= HALF_LO;
         wdata_q    <= '0;
         old_q      <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         mem_addr_q <= '0;
         lat_q      <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         if (state_q == IDLE && |arb_gnt) begin
            sel_q      <= arb_gnt[1];
            we_q       <= pick_we;
            half_q     <= pick_addr[0];
            wdata_q    <= pick_wdata;
            mem_addr_q <= pick_addr[HW_AW-1:1];
            lat_q      <= '0;
         end
         if (state_q == RD) lat_q <= lat_q + 3'd1;
         if (state_q == CAP) begin
            old_q <= bus.mem_do;
            if (!we_q) begin
               if (sel_q) rdata1_q <= pick_half(bus.mem_do, half_q);
               else       rdata0_q <= pick_half(bus.mem_do, half_q);
            end
         end
      end
   end

   // mem_we decodes straight from the state flop, so reset drops it at once.
   assign bus.mem_we   = (state_q == WR);
   assign bus.mem_di   = merge_half(old_q, wdata_q, half_q);
   assign bus.mem_addr = mem_addr_q;
   assign bus.gnt0     = arb_gnt[0];
   assign bus.gnt1     = arb_gnt[1];
   assign bus.done0    = (state_q == DONE) && !sel_q;
   assign bus.done1    = (state_q == DONE) &&  sel_q;
   assign bus.rdata0   = rdata0_q;
   assign bus.rdata1   = rdata1_q;
   assign bus.busy     = (state_q != IDLE);

`ifdef MEM_ARB_STATS_EN
   logic [HW_W-1:0] cnt0_q, cnt1_q;

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (bus.done0 && cnt0_q != '1) cnt0_q <= cnt0_q + 16'd1;
         if (bus.done1 && cnt1_q != '1) cnt1_q <= cnt1_q + 16'd1;
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;
`endif

endmodule
